// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, owner release,
// requester withdraw and an optional hold timeout with a one-cycle pulse.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic       HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q,     state_d;
    logic [2:0] ptr_q,       ptr_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [7:0] gnt_q,       gnt_d;
    logic [2:0] gnt_idx_q,   gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q,   timeout_d;

    logic       rel_done_s;
    logic       rel_wd_s;
    logic       rel_to_s;
    logic [2:0] pick_s;

    // Same 3-to-8 decode as the datapath slot select.
    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        logic [7:0] one_hot;
        one_hot = 8'h00;
        one_hot[idx] = 1'b1;
        return one_hot;
    endfunction

    // First requester at or after the pointer, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] sel;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick_s     = rr_pick(req, ptr_q);
    assign rel_done_s = done;
    assign rel_wd_s   = ~req[gnt_idx_q];
    assign rel_to_s   = HOLD_EN && (hold_cnt_q == HOLD_LAST);

    // Next-state logic for the grant FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_idx_d   = pick_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                    state_d     = ST_GRANT;
                end else begin
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_done_s || rel_wd_s || rel_to_s) begin
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    state_d     = ST_IDLE;
                    // A timeout coinciding with done or withdraw is a normal release.
                    timeout_d   = rel_to_s && !rel_done_s && !rel_wd_s;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d  = hold_cnt_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
        gnt_d = gnt_valid_d ? dec3to8(gnt_idx_d) : 8'h00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: stimulus queues expected grants, a
// negedge monitor pops one per new grant and checks index, length and timeout.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [2:0] idx;
        int         len;   // 0 means length not checked
        logic       to;    // expected timeout in the cycle after release
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] idx, input int len, input logic to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input logic lvl);
        int k;
        k = 0;
        while (gnt_valid !== lvl && k < 20) begin
            tick();
            k++;
        end
        if (gnt_valid !== lvl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_valid: gnt_valid stuck at %b expected %b at %0t", gnt_valid, lvl, $time);
        end
    endtask

    // Monitor: pops one expectation per new grant, checks it at release.
    initial begin
        exp_t cur;
        logic prev_valid;
        int   len_cnt;
        prev_valid = 1'b0;
        len_cnt    = 0;
        cur.idx = 3'd0; cur.len = 0; cur.to = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {29'd0, gnt_idx}, 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_idx", {29'd0, gnt_idx}, {29'd0, cur.idx});
                    check("grant_onehot", {24'd0, gnt}, 32'd1 << cur.idx);
                end
                len_cnt = 1;
            end else if (gnt_valid === 1'b1) begin
                len_cnt++;
                check("grant_stable", {24'd0, gnt}, 32'd1 << cur.idx);
            end
            if (gnt_valid !== 1'b1 && prev_valid === 1'b1) begin
                if (cur.len != 0) check("grant_len", len_cnt, cur.len);
                check("timeout_at_release", {31'd0, timeout}, {31'd0, cur.to});
            end else begin
                check("timeout_quiet", {31'd0, timeout}, 32'd0);
            end
            if (gnt_valid !== 1'b1) check("gnt_zero_idle", {24'd0, gnt}, 32'd0);
            prev_valid = gnt_valid;
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        tick();
        tick();
        check("rst_gnt",     {24'd0, gnt},       32'd0);
        check("rst_valid",   {31'd0, gnt_valid}, 32'd0);
        check("rst_idx",     {29'd0, gnt_idx},   32'd0);
        check("rst_timeout", {31'd0, timeout},   32'd0);

        // Rotation 0..7,0 with a done pulse one cycle after each grant.
        for (int i = 0; i < 9; i++) push(3'(i % 8), 1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_level(1'b1);
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        // ptr=1: grant 5, then ptr=6 with req 0010_0010 -> 1, then 5.
        push(3'd5, 1, 1'b0);
        req = 8'h20;
        wait_level(1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        push(3'd1, 1, 1'b0);
        push(3'd5, 1, 1'b0);
        req = 8'b0010_0010;
        for (int i = 0; i < 2; i++) begin
            wait_level(1'b1);
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        // Timeout with MAX_HOLD=4, then re-grant of the same port.
        push(3'd3, 4, 1'b1);
        push(3'd3, 1, 1'b0);
        req = 8'h08;
        wait_level(1'b1);
        wait_level(1'b0);
        wait_level(1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;

        // Withdraw by owner 2, then done while idle.
        push(3'd2, 2, 1'b0);
        req = 8'h04;
        wait_level(1'b1);
        tick();
        req = 8'h00;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("idle_done_valid", {31'd0, gnt_valid}, 32'd0);
        check("idle_done_gnt",   {24'd0, gnt},       32'd0);
        check("idle_done_idx",   {29'd0, gnt_idx},   32'd2);

        // Reset mid-grant at hold_cnt=3 (also the timeout edge).
        push(3'd4, 4, 1'b0);
        req = 8'h10;
        wait_level(1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_gnt",     {24'd0, gnt},       32'd0);
        check("midrst_valid",   {31'd0, gnt_valid}, 32'd0);
        check("midrst_idx",     {29'd0, gnt_idx},   32'd0);
        check("midrst_timeout", {31'd0, timeout},   32'd0);
        push(3'd4, 1, 1'b0);
        rst = 1'b0;
        wait_level(1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;

        // ptr is 5 here; a reset must bring it back to 0 (req 8'h81 -> idx 0).
        push(3'd0, 1, 1'b0);
        req = 8'h81;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_level(1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        repeat (5) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one decoded resource slot among eight requesters. It selects a 3-bit grant index, drives the matching one-hot grant line through the same 3-to-8 decode used in the datapath, and holds the grant until the owner releases it or a hold timeout expires. Rotating priority ensures that no continuously requesting port starves.

## Interface
- MAX_HOLD, 16: maximum cycles a grant is held before forced release; 0 disables the timeout; range 0..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  8  request lines; req[i] is the request from port i; level-sensitive.
- done  input  1  release pulse from the current owner; ignored unless a grant is active.
- gnt  output  8  one-hot grant, equal to the 3-to-8 decode of gnt_idx when gnt_valid=1; otherwise all zero.
- gnt_idx  output  3  index of the granted port; holds its last value while idle.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  single-cycle pulse in the cycle after a MAX_HOLD forced release.

## Operation
- State machine has two states: IDLE and GRANT. Reset state is IDLE.
- Priority pointer ptr is 3 bits and resets to 0.
- IDLE:
  - If req is nonzero, choose the first i with req[i]=1, scanning ptr, ptr+1, … ptr+7 modulo 8.
  - Register i into gnt_idx, set gnt_valid=1, clear hold_cnt, and move to GRANT.
  - If req is zero, stay in IDLE; outputs stay unchanged except that gnt remains zero.
- GRANT releases on any of the following, evaluated at each rising edge:
  - (a) done=1.
  - (b) req[gnt_idx]=0, meaning the requester withdrew.
  - (c) MAX_HOLD≠0 and hold_cnt=MAX_HOLD−1, meaning the timeout expired.
- Effects of a release:
  - gnt_valid goes to 0 and gnt goes to all zero.
  - ptr is set to gnt_idx+1, wrapping from 7 to 0.
  - The state returns to IDLE.
  - timeout is set to 1 only for cause (c) when neither (a) nor (b) also holds.
- If no release condition holds, hold_cnt increments by 1. hold_cnt is 8 bits and saturates at 255, which is reachable only when MAX_HOLD=0.
- gnt is registered: gnt[k]=1 exactly when gnt_valid=1 and gnt_idx=k. Exactly one bit is set while valid, and gnt never shows more than one bit.
- Changes to req while in GRANT, other than the owner's bit, have no effect on the current grant.
- done received while in IDLE is ignored.

## Timing
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state IDLE.
- rst=1 at any edge forces all reset values at that edge, including in the middle of a grant. rst has priority over every other input.
- Grant latency:
  - A request sampled at edge N, with the arbiter in IDLE, produces gnt/gnt_valid visible after edge N, during cycle N+1.
- Release latency:
  - done sampled at edge M clears gnt after edge M.
  - The earliest re-grant is at edge M+1, so there is one dead cycle with gnt=0 between consecutive grants.
- Timeout behaviour with MAX_HOLD=H:
  - A grant visible from cycle N+1 stays valid for exactly H cycles.
  - gnt is dropped after edge N+H.
  - timeout is high during cycle N+H+1 only.
- Simultaneous done and timeout at the same edge: this is a normal release with timeout=0.
- Pointer wrap: releasing index 7 sets ptr=0.

## Test plan
- Reset check: hold rst=1 for 2 cycles with req=8'hFF -> gnt=8'h00, gnt_valid=0, gnt_idx=0, timeout=0. Release rst -> after the next edge, gnt=8'h01 and gnt_idx=0.
- Round-robin rotation: hold req=8'hFF and pulse done one cycle after each grant -> the grant sequence is idx 0,1,2,…,7,0, each separated by exactly one cycle with gnt=0.
- Sparse requests with wrap: after idx 5 is released (ptr=6), set req=8'b0010_0010 -> grant goes to idx 1. After its release, the grant goes to idx 5.
- Timeout: MAX_HOLD=4, req=8'h08 held, done=0 -> gnt=8'h08 for exactly 4 cycles, then timeout is high for 1 cycle with gnt=0, then gnt=8'h08 is granted again.
- Withdraw and done in IDLE: owner idx 2 drops req[2] -> gnt clears after that edge with timeout=0. Pulse done while idle with req=0 -> no state change.
- Reset mid-grant: assert rst while gnt=8'h10 and hold_cnt=3 -> after the next edge, all outputs are at reset values. After rst is released with req=8'h10, the grant returns to idx 4 with ptr restarted at 0.
